branch_resolve_ctrl: RTL and testbench

// - Decode-stage branch sequencer: decodes conditional branches, waits for operands, evaluates the condition and issues a PC redirect to fetch.
// - Sits between ID (hazard/forwarding results) and IF (next-PC mux).
// - Holds the redirect until fetch accepts it; cancels on pipeline flush.
// - Keeps branch/taken performance counters.

---
 rtl/branch_resolve_ctrl_pkg.sv | 24 ++
 rtl/branch_resolve_ctrl_br_cond_eval.sv | 37 +++
 rtl/branch_resolve_ctrl.sv | 126 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants for the decode-stage branch sequencer: MIPS branch opcodes,
// REGIMM sub-ops, sequencer states and the branch-target helper.
package branch_resolve_ctrl_pkg;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_OPND = 2'd1,
        ST_REDIRECT  = 2'd2
    } state_e;

    function automatic logic [31:0] br_target(input logic [31:0] pc4, input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/branch_resolve_ctrl_br_cond_eval.sv
// Combinational branch decode and condition evaluation; a = rs, b = rt.
module br_cond_eval
    import branch_resolve_ctrl_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [4:0]  rt_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        is_br_o,
    output logic        taken_o,
    output logic        is_link_o
);
    logic a_zero;
    assign a_zero = (a_i == 32'd0);

    always_comb begin
        is_br_o   = 1'b0;
        taken_o   = 1'b0;
        is_link_o = 1'b0;
        case (op_i)
            OP_BEQ:  begin is_br_o = 1'b1; taken_o = (a_i == b_i);        end
            OP_BNE:  begin is_br_o = 1'b1; taken_o = (a_i != b_i);        end
            OP_BLEZ: begin is_br_o = 1'b1; taken_o = a_i[31] | a_zero;    end
            OP_BGTZ: begin is_br_o = 1'b1; taken_o = ~a_i[31] & ~a_zero;  end
            OP_REGIMM: begin
                case (rt_i)
                    RT_BLTZ, RT_BLTZAL: begin is_br_o = 1'b1; taken_o = a_i[31];  end
                    RT_BGEZ, RT_BGEZAL: begin is_br_o = 1'b1; taken_o = ~a_i[31]; end
                    default: ;
                endcase
                // Link variants write r31 regardless of the outcome
                is_link_o = is_br_o & rt_i[4];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch sequencer: waits for forwardable operands, resolves the
// branch, holds a PC redirect until fetch takes it, and counts branches.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rt,
    input  logic [15:0]      id_imm,
    input  logic [31:0]      id_pc_plus4,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             opnd_hazard,
    input  logic             flush,
    input  logic             redir_ready,
    output logic             stall_id,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic             is_link,
    output logic             opnd_timeout,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    localparam int              WC_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              redir_valid_q, opnd_timeout_q;
    logic [31:0]       redir_pc_q;
    logic [CNT_W-1:0]  br_cnt_q, taken_cnt_q;
    logic              dec_br, dec_taken, dec_link;
    logic              is_br, resolve, take;

    br_cond_eval u_cond (
        .op_i      (id_op),
        .rt_i      (id_rt),
        .a_i       (rs_val),
        .b_i       (rt_val),
        .is_br_o   (dec_br),
        .taken_o   (dec_taken),
        .is_link_o (dec_link)
    );

    assign is_br   = id_valid & dec_br;
    assign is_link = id_valid & dec_link;
    assign take    = resolve & dec_taken;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_br && opnd_hazard) state_d = ST_WAIT_OPND;
                    else if (take)            state_d = ST_REDIRECT;
                end
                ST_WAIT_OPND: if (!opnd_hazard) state_d = take ? ST_REDIRECT : ST_IDLE;
                ST_REDIRECT:  if (redir_ready)  state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // A flush cancels any resolve happening in the same cycle, so it is not counted
    always_comb begin
        stall_id = 1'b0;
        resolve  = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_IDLE: begin
                    stall_id = is_br & opnd_hazard;
                    resolve  = is_br & ~opnd_hazard;
                end
                ST_WAIT_OPND: begin
                    stall_id = opnd_hazard;
                    resolve  = is_br & ~opnd_hazard;
                end
                ST_REDIRECT: stall_id = is_br;
                default: ;
            endcase
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (!flush && state_q == ST_WAIT_OPND && opnd_hazard)
            wait_cnt_d = (wait_cnt_q == WC_MAX) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_q     <= '0;
            redir_valid_q  <= 1'b0;
            redir_pc_q     <= '0;
            opnd_timeout_q <= 1'b0;
            br_cnt_q       <= '0;
            taken_cnt_q    <= '0;
        end else begin
            wait_cnt_q     <= wait_cnt_d;
            redir_valid_q  <= (state_d == ST_REDIRECT);
            // Fires only on the cycle the saturating count first reaches the limit
            opnd_timeout_q <= (wait_cnt_d == WC_MAX) && (wait_cnt_q != WC_MAX);
            if (take)    redir_pc_q  <= br_target(id_pc_plus4, id_imm);
            if (resolve) br_cnt_q    <= br_cnt_q + CNT_W'(1);
            if (take)    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
        end
    end

    assign redir_valid  = redir_valid_q;
    assign redir_pc     = redir_pc_q;
    assign opnd_timeout = opnd_timeout_q;
    assign br_cnt       = br_cnt_q;
    assign taken_cnt    = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed and randomized checks of branch_resolve_ctrl against a per-instruction
// reference model (signed arithmetic for conditions and targets).
module tb_branch_resolve_ctrl;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             id_valid, opnd_hazard, flush, redir_ready;
    logic [5:0]       id_op;
    logic [4:0]       id_rt;
    logic [15:0]      id_imm;
    logic [31:0]      id_pc_plus4, rs_val, rt_val;
    logic             stall_id, redir_valid, is_link, opnd_timeout;
    logic [31:0]      redir_pc;
    logic [CNT_W-1:0] br_cnt, taken_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int m_br     = 0;
    int m_tk     = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_op(id_op), .id_rt(id_rt),
        .id_imm(id_imm), .id_pc_plus4(id_pc_plus4), .rs_val(rs_val), .rt_val(rt_val),
        .opnd_hazard(opnd_hazard), .flush(flush), .redir_ready(redir_ready),
        .stall_id(stall_id), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .is_link(is_link), .opnd_timeout(opnd_timeout), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_is_br(input logic [5:0] op, input logic [4:0] rt);
        return (op >= 6'd4 && op <= 6'd7) ||
               (op == 6'd1 && (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17));
    endfunction

    function automatic bit m_taken(input logic [5:0] op, input logic [4:0] rt,
                                   input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = int'(a);
        case (op)
            6'd4:    return a == b;
            6'd5:    return a != b;
            6'd6:    return sa <= 0;
            6'd7:    return sa > 0;
            6'd1:    return rt[0] ? (sa >= 0) : (sa < 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc4, input logic [15:0] imm);
        int off;
        off = int'($signed(imm)) * 4;
        return pc4 + 32'(off);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, " br_cnt"},    32'(br_cnt),    32'(m_br % 16));
        check({tag, " taken_cnt"}, 32'(taken_cnt), 32'(m_tk % 16));
    endtask

    // One instruction in ID: hz cycles of operand hazard, then fetch takes any
    // redirect after dly refusal cycles.
    task automatic do_instr(input string tag, input logic [5:0] op, input logic [4:0] rt,
                            input logic [15:0] imm, input logic [31:0] pc4,
                            input logic [31:0] a, input logic [31:0] b,
                            input int hz, input int dly);
        bit br, tk, lnk;
        logic [31:0] tgt;
        int to_seen;
        br  = m_is_br(op, rt);
        tk  = br && m_taken(op, rt, a, b);
        lnk = br && op == 6'd1 && rt[4];
        tgt = m_target(pc4, imm);
        to_seen = 0;
        id_valid = 1'b1; id_op = op; id_rt = rt; id_imm = imm;
        id_pc_plus4 = pc4; rs_val = a; rt_val = b; redir_ready = 1'b0;
        for (int i = 0; i < hz; i++) begin
            opnd_hazard = 1'b1;
            @(negedge clk);
            check({tag, " stall"}, 32'(stall_id), 32'(br));
            if (opnd_timeout) to_seen++;
            next_cycle();
        end
        opnd_hazard = 1'b0;
        @(negedge clk);
        check({tag, " stall_res"}, 32'(stall_id), 32'd0);
        check({tag, " is_link"},   32'(is_link),  32'(lnk));
        if (opnd_timeout) to_seen++;
        next_cycle();
        if (br) m_br++;
        if (tk) m_tk++;
        id_valid = 1'b0;
        if (tk) begin
            for (int d = 0; d < dly; d++) begin
                @(negedge clk);
                check({tag, " hold_valid"}, 32'(redir_valid), 32'd1);
                check({tag, " hold_pc"},    redir_pc,         tgt);
                next_cycle();
            end
            redir_ready = 1'b1;
            @(negedge clk);
            check({tag, " redir_pc"}, redir_pc, tgt);
            next_cycle();
            redir_ready = 1'b0;
        end
        @(negedge clk);
        check({tag, " drained"}, 32'(redir_valid), 32'd0);
        check({tag, " timeout_cnt"}, 32'(to_seen), 32'((br && hz - 1 >= WAIT_MAX) ? 1 : 0));
        check_counters(tag);
        next_cycle();
    endtask

    initial begin
        logic [5:0]  ops [8];
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] a, b, tgt1, tgt2;
        ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd35, 6'd0};
        resetn = 1'b0; id_valid = 1'b0; id_op = '0; id_rt = '0; id_imm = '0;
        id_pc_plus4 = '0; rs_val = '0; rt_val = '0; opnd_hazard = 1'b0;
        flush = 1'b0; redir_ready = 1'b0;
        #12;
        check("reset redir_valid", 32'(redir_valid), 32'd0);
        check("reset redir_pc", redir_pc, 32'd0);
        check("reset timeout", 32'(opnd_timeout), 32'd0);
        check_counters("reset");
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        do_instr("t1 beq", 6'd4, 5'd0, 16'h0003, 32'h0040_0004, 32'd5, 32'd5, 0, 0);
        check("t1 taken const", 32'(taken_cnt), 32'd1);
        do_instr("t2 bne", 6'd5, 5'd0, 16'h0003, 32'h0040_0004, 32'd7, 32'd7, 0, 0);
        check("t2 br const", 32'(br_cnt), 32'd2);
        do_instr("t3 bgezal", 6'd1, 5'd17, 16'h0010, 32'h0000_1000, 32'h8000_0000, 32'd0, 0, 0);
        do_instr("t3 bgez back", 6'd1, 5'd1, 16'hFFFF, 32'h0000_2000, 32'd0, 32'd9, 0, 1);
        do_instr("t4 bgtz hz", 6'd7, 5'd0, 16'h0020, 32'h0000_3000, 32'd1, 32'd0, 3, 0);
        do_instr("nonbr hz", 6'd35, 5'd4, 16'h0020, 32'h0000_3000, 32'd1, 32'd0, 2, 0);

        // Branch waiting behind an undrained redirect
        id_valid = 1'b1; id_op = 6'd4; id_rt = 5'd0; id_imm = 16'h0010;
        id_pc_plus4 = 32'h0000_1000; rs_val = 32'd3; rt_val = 32'd3;
        tgt1 = m_target(32'h0000_1000, 16'h0010);
        next_cycle();
        m_br++; m_tk++;
        id_op = 6'd35;
        @(negedge clk);
        check("t5 slot stall", 32'(stall_id), 32'd0);
        check("t5 slot valid", 32'(redir_valid), 32'd1);
        next_cycle();
        id_op = 6'd4; id_imm = 16'h8000; id_pc_plus4 = 32'h0000_2000;
        tgt2 = m_target(32'h0000_2000, 16'h8000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5 stall", 32'(stall_id), 32'd1);
            check("t5 pc held", redir_pc, tgt1);
            next_cycle();
        end
        redir_ready = 1'b1;
        @(negedge clk);
        check("t5 accept stall", 32'(stall_id), 32'd1);
        next_cycle();
        redir_ready = 1'b0;
        @(negedge clk);
        check("t5 resolve stall", 32'(stall_id), 32'd0);
        check("t5 gap valid", 32'(redir_valid), 32'd0);
        next_cycle();
        m_br++; m_tk++;
        id_valid = 1'b0;
        @(negedge clk);
        check("t5 new pc", redir_pc, tgt2);
        check("t5 new valid", 32'(redir_valid), 32'd1);
        check_counters("t5");
        next_cycle();

        // Flush with redir_ready in REDIRECT
        id_valid = 1'b1; flush = 1'b1; redir_ready = 1'b1;
        @(negedge clk);
        check("t6 flush stall", 32'(stall_id), 32'd0);
        next_cycle();
        flush = 1'b0; redir_ready = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        check("t6 flush valid", 32'(redir_valid), 32'd0);
        next_cycle();
        // Taken branch resolving under flush is dropped and not counted
        id_valid = 1'b1; id_pc_plus4 = 32'h0000_5000; flush = 1'b1;
        @(negedge clk);
        check("t6 flush res stall", 32'(stall_id), 32'd0);
        next_cycle();
        flush = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        check("t6 flush res valid", 32'(redir_valid), 32'd0);
        check_counters("t6 flush");
        next_cycle();

        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 7)];
            rt = 5'($urandom_range(0, 31));
            if (op == 6'd1 && $urandom_range(0, 3) != 0) rt = {rt[4], 3'b000, rt[0]};
            case ($urandom_range(0, 3))
                0: a = 32'd0;
                1: a = 32'd1;
                2: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            do_instr("rand", op, rt, 16'($urandom), $urandom, a, b,
                     $urandom_range(0, 4), $urandom_range(0, 3));
        end

        // Reset while waiting on operands
        id_valid = 1'b1; id_op = 6'd4; id_imm = 16'h0004; rs_val = 32'd1; rt_val = 32'd1;
        opnd_hazard = 1'b1;
        next_cycle();
        next_cycle();
        resetn = 1'b0; id_valid = 1'b0; opnd_hazard = 1'b0;
        #1;
        m_br = 0; m_tk = 0;
        check("rst stall", 32'(stall_id), 32'd0);
        check("rst valid", 32'(redir_valid), 32'd0);
        check("rst pc", redir_pc, 32'd0);
        check("rst timeout", 32'(opnd_timeout), 32'd0);
        check_counters("rst");
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        do_instr("post rst", 6'd6, 5'd0, 16'h0001, 32'h0000_0100, 32'd0, 32'd0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
